// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter owner and two-byte (opcode, operand) fetch sequencer.
// Latency: 3 cycles per instruction with zero-wait memory; each memory wait cycle adds one.
// Backpressure: mem_req/mem_addr held until mem_ack; instr_valid held until exec_done.
// Optional single-step support is built when FETCH_STEP_EN is defined.
module fetch_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
`ifdef FETCH_STEP_EN
    input  logic              step,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              iru_en,
    output logic              irl_en,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              br_take,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FETCH_HI = 2'd1;
    localparam logic [1:0] FETCH_LO = 2'd2;
    localparam logic [1:0] EXEC     = 2'd3;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] pc_nxt;

`ifdef FETCH_STEP_EN
    // Set while the single instruction launched by a step pulse is in flight.
    logic step_mode;
    logic step_mode_nxt;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
`ifdef FETCH_STEP_EN
        step_mode_nxt = step_mode;
`endif
        case (state)
            IDLE: begin
                if (!halt) begin
                    state_nxt = FETCH_HI;
                end
`ifdef FETCH_STEP_EN
                else if (step) begin
                    state_nxt     = FETCH_HI;
                    step_mode_nxt = 1'b1;
                end
`endif
            end
            FETCH_HI: begin
                if (mem_ack) begin
                    pc_nxt    = pc + PC_ONE;
                    state_nxt = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (mem_ack) begin
                    pc_nxt    = pc + PC_ONE;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    if (br_take) begin
                        pc_nxt = br_target;
                    end
                    state_nxt = halt ? IDLE : FETCH_HI;
`ifdef FETCH_STEP_EN
                    if (step_mode) begin
                        state_nxt     = IDLE;
                        step_mode_nxt = 1'b0;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

`ifdef FETCH_STEP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_mode <= 1'b0;
        end else begin
            step_mode <= step_mode_nxt;
        end
    end
`endif

    // Outputs decode straight from the state register, so reset clears them asynchronously.
    assign mem_req     = (state == FETCH_HI) || (state == FETCH_LO);
    assign mem_addr    = pc;
    assign iru_en      = (state == FETCH_HI) && mem_ack;
    assign irl_en      = (state == FETCH_LO) && mem_ack;
    assign instr_valid = (state == EXEC);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: two instances (RESET_PC 0x00 and 0xFF) share all inputs.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       halt = 1'b0;
`ifdef FETCH_STEP_EN
    logic       step = 1'b0;
`endif
    logic       mem_ack = 1'b0;
    logic       exec_done = 1'b0;
    logic       br_take = 1'b0;
    logic [7:0] br_target = 8'h00;

    logic       mem_req, iru_en, irl_en, instr_valid, busy;
    logic [7:0] mem_addr, pc;
    logic       mem_req2, iru_en2, irl_en2, instr_valid2, busy2;
    logic [7:0] mem_addr2, pc2;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .halt(halt),
`ifdef FETCH_STEP_EN
        .step(step),
`endif
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .iru_en(iru_en), .irl_en(irl_en), .instr_valid(instr_valid),
        .exec_done(exec_done), .br_take(br_take), .br_target(br_target),
        .pc(pc), .busy(busy)
    );

    fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'hFF)) dut2 (
        .clk(clk), .rst(rst), .halt(halt),
`ifdef FETCH_STEP_EN
        .step(step),
`endif
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack),
        .iru_en(iru_en2), .irl_en(irl_en2), .instr_valid(instr_valid2),
        .exec_done(exec_done), .br_take(br_take), .br_target(br_target),
        .pc(pc2), .busy(busy2)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] addr2;
        bit         hi;
        int         cyc;
    } acc_t;

    typedef struct {
        logic [15:0] ir;
        logic [7:0]  pc;
        logic [7:0]  pc2;
        int          cyc;
    } ins_t;

    acc_t acc_q[$];
    ins_t ins_q[$];

    int         checks = 0;
    int         failures = 0;
    int         cyc;
    int         wait_n = 0;
    bit         junk_ack = 1'b0;
    bit         junk_exec = 1'b0;
    logic [7:0] mdr = 8'h00;
    logic [7:0] mem [256];

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_acc(input logic [7:0] a, input logic [7:0] a2, input bit hi, input int c);
        acc_t e;
        e.addr = a; e.addr2 = a2; e.hi = hi; e.cyc = c;
        acc_q.push_back(e);
    endtask

    task automatic exp_ins(input logic [15:0] ir, input logic [7:0] p, input logic [7:0] p2, input int c);
        ins_t e;
        e.ir = ir; e.pc = p; e.pc2 = p2; e.cyc = c;
        ins_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench 1ns into cycle 0 after release.
    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (acc_q.size() != 0 || ins_q.size() != 0); i++) tick(1);
        if (acc_q.size() != 0 || ins_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d fetches and %0d instructions still expected", acc_q.size(), ins_q.size());
            acc_q.delete();
            ins_q.delete();
        end
        tick(3);
    endtask

    // Program memory: answers after wait_n extra request cycles.
    initial begin : mem_resp
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (cnt >= wait_n) begin
                    mem_ack = 1'b1;
                    mdr = mem[mem_addr];
                    cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ack = junk_ack;
                mdr = 8'h00;
                cnt = 0;
            end
        end
    end

    initial begin : exec_resp
        forever begin
            @(posedge clk);
            #1;
            exec_done = instr_valid ? 1'b1 : junk_exec;
        end
    end

    initial begin : monitor
        logic        prev_req, prev_ack, prev_iv;
        logic [7:0]  prev_addr;
        logic [15:0] ir_m;
        acc_t        e;
        ins_t        ie;
        prev_req = 1'b0; prev_ack = 1'b0; prev_iv = 1'b0; prev_addr = 8'h00; ir_m = 16'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0; prev_ack = 1'b0; prev_iv = 1'b0;
            end else begin
                if (mem_req && prev_req && !prev_ack) chk("addr_stable", mem_addr, prev_addr);
                if (mem_ack && !mem_req) chk("ignored_ack_strobes", {iru_en, irl_en}, 2'b00);
                if (instr_valid) chk("no_req_in_exec", mem_req, 1'b0);
                if (mem_req && mem_ack) begin
                    if (acc_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_fetch: addr %0h, no fetch expected", mem_addr);
                    end else begin
                        e = acc_q.pop_front();
                        chk("fetch_addr", mem_addr, e.addr);
                        chk("fetch_addr_pcff", mem_addr2, e.addr2);
                        chk("ir_strobes", {iru_en, irl_en}, e.hi ? 2'b10 : 2'b01);
                        chk("ir_strobes_pcff", {mem_req2, iru_en2, irl_en2}, e.hi ? 3'b110 : 3'b101);
                        if (e.cyc >= 0) chk("fetch_cycle", cyc, e.cyc);
                    end
                    if (iru_en) ir_m[15:8] = mdr;
                    if (irl_en) ir_m[7:0] = mdr;
                end
                if (instr_valid && !prev_iv) begin
                    if (ins_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_instr: pc %0h, no instruction expected", pc);
                    end else begin
                        ie = ins_q.pop_front();
                        chk("instr_ir", ir_m, ie.ir);
                        chk("instr_pc", pc, ie.pc);
                        chk("instr_pc_pcff", pc2, ie.pc2);
                        chk("instr_flags_pcff", {instr_valid2, busy2}, 2'b11);
                        if (ie.cyc >= 0) chk("instr_cycle", cyc, ie.cyc);
                    end
                end
                prev_req = mem_req; prev_ack = mem_ack; prev_iv = instr_valid; prev_addr = mem_addr;
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
        mem[8'h40] = 8'hA5; mem[8'h41] = 8'h5A; mem[8'hFF] = 8'hEE;

        // Reset values.
        tick(2);
        chk("rst_outputs", {mem_req, iru_en, irl_en, instr_valid, busy}, 5'b0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_pc_pcff", pc2, 8'hFF);
        chk("rst_mem_addr_pcff", mem_addr2, 8'hFF);

        // Zero-wait fetch, halt taken at exec_done, then resume at the current pc.
        halt = 1'b0;
        rst = 1'b0;
        exp_acc(8'h00, 8'hFF, 1'b1, 1);
        exp_acc(8'h01, 8'h00, 1'b0, 2);
        exp_ins(16'h1234, 8'h02, 8'h01, 3);
        tick(1);
        halt = 1'b1;
        tick(4);
        chk("halt_idle", {busy, mem_req}, 2'b00);
        chk("halt_pc", pc, 8'h02);
        tick(3);
        chk("halt_stays_idle", {busy, mem_req}, 2'b00);
        exp_acc(8'h02, 8'h01, 1'b1, -1);
        exp_acc(8'h03, 8'h02, 1'b0, -1);
        exp_ins(16'h5678, 8'h04, 8'h03, -1);
        halt = 1'b0;
        tick(1);
        halt = 1'b1;
        drain();

        // Three wait cycles per byte; stray acks outside a request must be ignored.
        halt = 1'b0;
        wait_n = 3;
        junk_ack = 1'b1;
        do_reset();
        exp_acc(8'h00, 8'hFF, 1'b1, 4);
        exp_acc(8'h01, 8'h00, 1'b0, 8);
        exp_ins(16'h1234, 8'h02, 8'h01, 9);
        tick(1);
        halt = 1'b1;
        drain();
        chk("pc_after_junk_ack", pc, 8'h02);
        junk_ack = 1'b0;
        wait_n = 0;

        // Branch at exec_done; stray exec_done/br_take outside EXEC must be ignored.
        halt = 1'b0;
        br_take = 1'b1;
        br_target = 8'h40;
        junk_exec = 1'b1;
        do_reset();
        exp_acc(8'h00, 8'hFF, 1'b1, 1);
        exp_acc(8'h01, 8'h00, 1'b0, 2);
        exp_ins(16'h1234, 8'h02, 8'h01, 3);
        exp_acc(8'h40, 8'h40, 1'b1, 4);
        exp_acc(8'h41, 8'h41, 1'b0, 5);
        exp_ins(16'hA55A, 8'h42, 8'h42, 6);
        tick(4);
        halt = 1'b1;
        br_take = 1'b0;
        drain();
        junk_exec = 1'b0;

        // Asynchronous reset while the operand fetch waits for ack.
        halt = 1'b0;
        wait_n = 5;
        do_reset();
        exp_acc(8'h00, 8'hFF, 1'b1, 6);
        tick(1);
        halt = 1'b1;
        tick(7);
        #2;
        chk("lo_waiting", {mem_req, mem_addr}, {1'b1, 8'h01});
        rst = 1'b1;
        #1;
        chk("arst_outputs", {mem_req, iru_en, irl_en, instr_valid, busy}, 5'b0);
        chk("arst_pc", {pc, mem_addr}, 16'h0000);
        chk("arst_pc_pcff", pc2, 8'hFF);
        wait_n = 0;
        halt = 1'b0;
        do_reset();
        exp_acc(8'h00, 8'hFF, 1'b1, 1);
        exp_acc(8'h01, 8'h00, 1'b0, 2);
        exp_ins(16'h1234, 8'h02, 8'h01, 3);
        tick(1);
        halt = 1'b1;
        drain();

`ifdef FETCH_STEP_EN
        // Single step under halt, returning to IDLE even though halt drops during EXEC.
        halt = 1'b1;
        do_reset();
        exp_acc(8'h00, 8'hFF, 1'b1, 2);
        exp_acc(8'h01, 8'h00, 1'b0, 3);
        exp_ins(16'h1234, 8'h02, 8'h01, 4);
        tick(1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        halt = 1'b0;
        tick(1);
        chk("step_return_idle", busy, 1'b0);
        halt = 1'b1;
        drain();
        chk("step_pc", pc, 8'h02);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
